// File: rtl/ca_ctrl.sv
// -----------------------------------------------------------------------------
// ca_ctrl
// Draws a one-dimensional elementary cellular automaton on a VGA adapter. Each
// generation is one pixel row. The seed and the Wolfram rule are held in
// registers that keep their values from one run to the next.
//
// Parameters
//   CELLS   cells per generation (pixel columns), at least 9, at most 256
//   ROWS    generations per run (pixel rows), at most 128
//   DELAY   idle cycles between generations (0 = none)
//
// Ports
//   CLOCK_50    in   sole clock, rising edge
//   resetn      in   asynchronous active-low reset
//   load_init   in   capture init_state into the seed register (IDLE/DONE only)
//   init_state  in   9-bit seed pattern, centred on the row
//   load_rule   in   capture rule into the rule register (IDLE/DONE only)
//   rule        in   8-bit Wolfram rule number
//   start       in   begin a run (IDLE/DONE only)
//   x, y        out  pixel column / row
//   colour      out  3'b111 for a live cell, 3'b000 for a dead one
//   plot        out  pixel write strobe
//   busy        out  run in progress
//   done        out  run finished, held until the next start
// -----------------------------------------------------------------------------
module ca_ctrl #(
   parameter int CELLS = 160,
   parameter int ROWS  = 120,
   parameter int DELAY = 0
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       load_init,
   input  logic [8:0] init_state,
   input  logic       load_rule,
   input  logic [7:0] rule,
   input  logic       start,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
      DRAW,
      STEP,
      WAIT,
      DONE
   } state_t;

   // The wait counter is loaded with DELAY-1 and counts down to zero.
   localparam int         WCW       = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam logic [7:0] X_LAST    = 8'(CELLS - 1);
   localparam logic [6:0] Y_LAST    = 7'(ROWS - 1);
   localparam int         SEED_BASE = CELLS / 2 - 4;

   state_t             state_q,  state_d;
   logic [8:0]         seed_q,   seed_d;
   logic [7:0]         rule_q,   rule_d;
   logic [CELLS-1:0]   row_q,    row_d;
   logic [7:0]         x_q,      x_d;
   logic [6:0]         y_q,      y_d;
   logic [2:0]         colour_q, colour_d;
   logic               plot_q,   plot_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic [WCW-1:0]     wait_q,   wait_d;

   logic [8:0]         seed_src;
   logic [CELLS-1:0]   seed_row;
   logic [CELLS-1:0]   next_row;
   logic [CELLS-1:0]   row_sh;
   logic [7:0]         x_inc;

   // A load on the same edge as start must take effect for that run, so the
   // working row is built from the incoming pattern rather than the register.
   assign seed_src = load_init ? init_state : seed_q;

   // Seed bit 8 lands on cell CELLS/2-4, bit 0 on cell CELLS/2+4.
   genvar gi;
   generate
      for (gi = 0; gi < CELLS; gi++) begin : g_seed
         if (gi >= SEED_BASE && gi < SEED_BASE + 9) begin : g_in
            assign seed_row[gi] = seed_src[8 - (gi - SEED_BASE)];
         end else begin : g_out
            assign seed_row[gi] = 1'b0;
         end
      end
   endgenerate

   // Next generation, all cells in parallel; neighbours wrap around the row.
   generate
      for (gi = 0; gi < CELLS; gi++) begin : g_next
         localparam int LEFT  = (gi + CELLS - 1) % CELLS;
         localparam int RIGHT = (gi + 1) % CELLS;
         assign next_row[gi] = rule_q[{row_q[LEFT], row_q[gi], row_q[RIGHT]}];
      end
   endgenerate

   // Cell under the column about to be plotted, selected by shifting the row
   // so that any x width indexes safely.
   assign x_inc  = x_q + 8'd1;
   assign row_sh = row_q >> x_inc;

   always_comb begin
      state_d  = state_q;
      seed_d   = seed_q;
      rule_d   = rule_q;
      row_d    = row_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = 3'b000;
      plot_d   = 1'b0;
      busy_d   = busy_q;
      done_d   = done_q;
      wait_d   = wait_q;

      case (state_q)
         IDLE, DONE: begin
            if (load_init) seed_d = init_state;
            if (load_rule) rule_d = rule;
            if (start) begin
               row_d    = seed_row;
               x_d      = 8'd0;
               y_d      = 7'd0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               plot_d   = 1'b1;
               colour_d = {3{seed_row[0]}};
               state_d  = DRAW;
            end
         end

         DRAW: begin
            if (x_q == X_LAST) begin
               if (y_q == Y_LAST) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = STEP;
               end
            end else begin
               x_d      = x_inc;
               plot_d   = 1'b1;
               colour_d = {3{row_sh[0]}};
            end
         end

         STEP: begin
            row_d = next_row;
            x_d   = 8'd0;
            y_d   = y_q + 7'd1;
            if (DELAY == 0) begin
               // Straight back to drawing: the first pixel of the new row
               // comes from the generation being written this edge.
               plot_d   = 1'b1;
               colour_d = {3{next_row[0]}};
               state_d  = DRAW;
            end else begin
               wait_d  = WCW'(DELAY - 1);
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (wait_q == '0) begin
               plot_d   = 1'b1;
               colour_d = {3{row_q[0]}};
               state_d  = DRAW;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         seed_q   <= '0;
         rule_q   <= '0;
         row_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         seed_q   <= seed_d;
         rule_q   <= rule_d;
         row_q    <= row_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         wait_q   <= wait_d;
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_ca_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ca_ctrl
// Three instances of ca_ctrl share clock, reset and load inputs; each has its
// own start. Only one runs at a time. Expected pixels are queued before each
// start and a negedge monitor pops one per plot, also checking the number of
// non-plot cycles before the first pixel of every row after row 0.
//   dut 0: CELLS=160 ROWS=4 DELAY=0
//   dut 1: CELLS=16  ROWS=6 DELAY=0
//   dut 2: CELLS=16  ROWS=3 DELAY=3
// -----------------------------------------------------------------------------
module tb_ca_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       load_init;
   logic       load_rule;
   logic [8:0] init_state;
   logic [7:0] rule;
   logic [2:0] start_v;

   logic [7:0] xo [3];
   logic [6:0] yo [3];
   logic [2:0] co [3];
   logic [2:0] plot_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;

   typedef struct packed {
      logic [1:0] d;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   gap   = 0;
   int   cyc;

   always #5 clk = ~clk;

   ca_ctrl #(.CELLS(160), .ROWS(4), .DELAY(0)) u_a (
      .CLOCK_50(clk), .resetn(resetn), .load_init(load_init),
      .init_state(init_state), .load_rule(load_rule), .rule(rule),
      .start(start_v[0]), .x(xo[0]), .y(yo[0]), .colour(co[0]),
      .plot(plot_v[0]), .busy(busy_v[0]), .done(done_v[0]));

   ca_ctrl #(.CELLS(16), .ROWS(6), .DELAY(0)) u_b (
      .CLOCK_50(clk), .resetn(resetn), .load_init(load_init),
      .init_state(init_state), .load_rule(load_rule), .rule(rule),
      .start(start_v[1]), .x(xo[1]), .y(yo[1]), .colour(co[1]),
      .plot(plot_v[1]), .busy(busy_v[1]), .done(done_v[1]));

   ca_ctrl #(.CELLS(16), .ROWS(3), .DELAY(3)) u_c (
      .CLOCK_50(clk), .resetn(resetn), .load_init(load_init),
      .init_state(init_state), .load_rule(load_rule), .rule(rule),
      .start(start_v[2]), .x(xo[2]), .y(yo[2]), .colour(co[2]),
      .plot(plot_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   function automatic int exp_gap(input int d);
      return (d == 2) ? 4 : 1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   // Queue one row of expected pixels; white at the listed columns, or all.
   task automatic push_row(input int d, input int cells, input int r,
                           input int w[4], input bit all);
      pix_t p;
      for (int i = 0; i < cells; i++) begin
         p.d = 2'(d);
         p.x = 8'(i);
         p.y = 7'(r);
         p.c = (all || i == w[0] || i == w[1] || i == w[2] || i == w[3])
               ? 3'b111 : 3'b000;
         exp_q.push_back(p);
      end
   endtask

   task automatic push_sierpinski();
      push_row(0, 160, 0, '{80, -1, -1, -1}, 1'b0);
      push_row(0, 160, 1, '{79, 81, -1, -1}, 1'b0);
      push_row(0, 160, 2, '{78, 82, -1, -1}, 1'b0);
      push_row(0, 160, 3, '{77, 79, 81, 83}, 1'b0);
   endtask

   // Called at a negedge; returns at the next negedge, the first plot cycle.
   task automatic issue_start(input int d, input bit li, input logic [8:0] iv,
                              input bit lr, input logic [7:0] rv);
      init_state = iv;
      load_init  = li;
      rule       = rv;
      load_rule  = lr;
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v   = '0;
      load_init = 1'b0;
      load_rule = 1'b0;
   endtask

   // Counts cycles from the first plot until done. Optionally pulses loads and
   // start 100 cycles in, which the busy block must ignore.
   task automatic run_until_done(input int d, input int limit, input bit pulse,
                                 output int c);
      c = 0;
      while (!done_v[d] && c < limit) begin
         if (pulse && c == 100) begin
            rule       = 8'hFF;
            load_rule  = 1'b1;
            init_state = 9'h1FF;
            load_init  = 1'b1;
            start_v[d] = 1'b1;
         end
         @(negedge clk);
         c++;
         load_rule = 1'b0;
         load_init = 1'b0;
         start_v   = '0;
      end
      if (!done_v[d]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout dut%0d: got done=0 after %0d cycles expected done=1", d, c);
      end
   endtask

   // Monitor: every plot must match the head of the expected queue.
   always @(negedge clk) begin
      pix_t p;
      logic any;
      any = 1'b0;
      for (int d = 0; d < 3; d++) begin
         if (plot_v[d]) begin
            any = 1'b1;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_plot dut%0d: got x=%0d y=%0d c=%0d expected no plot",
                        d, xo[d], yo[d], co[d]);
            end else begin
               p = exp_q.pop_front();
               if (p.d != 2'(d) || p.x != xo[d] || p.y != yo[d] || p.c != co[d]) begin
                  n_bad++;
                  $display("FAIL pixel dut%0d: got x=%0d y=%0d c=%0d expected dut%0d x=%0d y=%0d c=%0d",
                           d, xo[d], yo[d], co[d], p.d, p.x, p.y, p.c);
               end else begin
                  $display("pix  dut%0d x=%0d y=%0d c=%0d", d, xo[d], yo[d], co[d]);
               end
            end
            if (xo[d] == 8'd0 && yo[d] != 7'd0) begin
               n_cmp++;
               if (gap != exp_gap(d)) begin
                  n_bad++;
                  $display("FAIL row_gap dut%0d y=%0d: got %0d idle cycles expected %0d",
                           d, yo[d], gap, exp_gap(d));
               end
            end
         end
      end
      gap = any ? 0 : gap + 1;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn     = 1'b0;
      load_init  = 1'b0;
      load_rule  = 1'b0;
      init_state = '0;
      rule       = '0;
      start_v    = '0;
      repeat (3) @(negedge clk);
      check("reset_plot",   int'(plot_v[0]), 0);
      check("reset_busy",   int'(busy_v[0]), 0);
      check("reset_done",   int'(done_v[0]), 0);
      check("reset_x",      int'(xo[0]), 0);
      check("reset_y",      int'(yo[0]), 0);
      check("reset_colour", int'(co[0]), 0);
      resetn = 1'b1;
      @(negedge clk);

      // Run 1: Sierpinski, seed and rule loaded on the start edge,
      // loads and start pulsed mid-run must be ignored.
      push_sierpinski();
      issue_start(0, 1'b1, 9'b000010000, 1'b1, 8'h5A);
      check("first_plot_latency", int'(plot_v[0]), 1);
      check("run1_busy", int'(busy_v[0]), 1);
      run_until_done(0, 2000, 1'b1, cyc);
      check("run1_cycles", cyc, 643);
      check("run1_busy_end", int'(busy_v[0]), 0);
      check("run1_x_hold", int'(xo[0]), 159);
      check("run1_y_hold", int'(yo[0]), 3);
      check("run1_pixels_left", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      check("done_held", int'(done_v[0]), 1);

      // Run 2: restart from DONE with stored seed and rule.
      push_sierpinski();
      issue_start(0, 1'b0, 9'h000, 1'b0, 8'h00);
      check("restart_busy", int'(busy_v[0]), 1);
      check("restart_done", int'(done_v[0]), 0);
      run_until_done(0, 2000, 1'b0, cyc);
      check("run2_cycles", cyc, 643);
      check("run2_pixels_left", exp_q.size(), 0);

      // Run 3: rule 8'hFF loaded in DONE -> every cell white from row 1.
      push_row(0, 160, 0, '{80, -1, -1, -1}, 1'b0);
      for (int r = 1; r < 4; r++) push_row(0, 160, r, '{-1, -1, -1, -1}, 1'b1);
      issue_start(0, 1'b0, 9'h000, 1'b1, 8'hFF);
      run_until_done(0, 2000, 1'b0, cyc);
      check("run3_pixels_left", exp_q.size(), 0);

      // Run 4: reset in the middle of DRAW.
      push_row(0, 160, 0, '{80, -1, -1, -1}, 1'b0);
      issue_start(0, 1'b0, 9'h000, 1'b0, 8'h00);
      repeat (30) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("midreset_plot", int'(plot_v[0]), 0);
      check("midreset_busy", int'(busy_v[0]), 0);
      check("midreset_done", int'(done_v[0]), 0);
      check("midreset_x",    int'(xo[0]), 0);
      check("midreset_y",    int'(yo[0]), 0);
      exp_q.delete();
      @(negedge clk);
      resetn = 1'b1;
      repeat (10) @(negedge clk);
      check("post_reset_busy", int'(busy_v[0]), 0);
      check("post_reset_done", int'(done_v[0]), 0);

      // Wrap-around: rule 2 shifts a single cell left through cell 0 to 15.
      push_row(1, 16, 0, '{4, -1, -1, -1}, 1'b0);
      push_row(1, 16, 1, '{3, -1, -1, -1}, 1'b0);
      push_row(1, 16, 2, '{2, -1, -1, -1}, 1'b0);
      push_row(1, 16, 3, '{1, -1, -1, -1}, 1'b0);
      push_row(1, 16, 4, '{0, -1, -1, -1}, 1'b0);
      push_row(1, 16, 5, '{15, -1, -1, -1}, 1'b0);
      issue_start(1, 1'b1, 9'b100000000, 1'b1, 8'h02);
      run_until_done(1, 500, 1'b0, cyc);
      check("wrap_cycles", cyc, 101);
      check("wrap_x_hold", int'(xo[1]), 15);
      check("wrap_y_hold", int'(yo[1]), 5);
      check("wrap_pixels_left", exp_q.size(), 0);

      // Pacing with DELAY=3: 4 idle cycles between rows.
      push_row(2, 16, 0, '{8, -1, -1, -1}, 1'b0);
      push_row(2, 16, 1, '{7, 9, -1, -1}, 1'b0);
      push_row(2, 16, 2, '{6, 10, -1, -1}, 1'b0);
      issue_start(2, 1'b1, 9'b000010000, 1'b1, 8'h5A);
      run_until_done(2, 500, 1'b0, cyc);
      check("delay_cycles", cyc, 56);
      check("delay_pixels_left", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
